// File: rtl/pipe_stage_pkg.sv
// Shared defines for the ID->EX pipeline register slice:
// stage state encoding, payload field widths and NOP constants.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int unsigned ALUOP_W   = 7;
  localparam int unsigned ALUSEL_W  = 3;
  localparam int unsigned REG_W     = 32;
  localparam int unsigned REGADDR_W = 5;

  localparam logic [ALUOP_W-1:0]   EXE_NOP_OP  = '0;
  localparam logic [ALUSEL_W-1:0]  EXE_RES_NOP = '0;
  localparam logic [REGADDR_W-1:0] NOPRegAddr  = '0;
  localparam logic [REG_W-1:0]     ZeroWord    = '0;

  typedef struct packed {
    logic [ALUOP_W-1:0]   aluop;
    logic [ALUSEL_W-1:0]  alusel;
    logic [REG_W-1:0]     reg1;
    logic [REG_W-1:0]     reg2;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
  } id_ex_t;

  localparam int unsigned ID_EX_W = $bits(id_ex_t);

  localparam id_ex_t ID_EX_NOP = '{
    aluop:  EXE_NOP_OP,
    alusel: EXE_RES_NOP,
    reg1:   ZeroWord,
    reg2:   ZeroWord,
    wd:     NOPRegAddr,
    wreg:   1'b0
  };

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports: clk, rst, inc (count enable), clr (clear, wins), cnt.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with optional skid entry,
// flush, bubble payload and a saturating back-pressure counter.
// Ports: clk, rst (sync, high), flush, up_valid/up_ready/up_data,
// dn_valid/dn_ready/dn_data, stall_cnt, cnt_clr.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W    = ID_EX_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(ID_EX_NOP),
  parameter bit                SKID      = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic              up_xfer;
  logic              dn_xfer;

  assign dn_valid = (state_q != ST_EMPTY);
  assign dn_data  = dn_valid ? main_q : NOP_VALUE;

  // Skid mode: ready is a flop; otherwise ready looks through.
  assign up_ready = SKID ? rdy_q : (!dn_valid || dn_ready);

  assign up_xfer = up_valid && up_ready;
  assign dn_xfer = dn_valid && dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_ONE;
            main_d  = up_data;
          end
        end
        ST_ONE: begin
          unique case (1'b1)
            (up_xfer && dn_xfer): begin
              main_d = up_data;
            end
            (!up_xfer && dn_xfer): begin
              state_d = ST_EMPTY;
            end
            (up_xfer && !dn_xfer && SKID): begin
              state_d = ST_TWO;
              skid_d  = up_data;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (dn_xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
    rdy_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(dn_valid && !dn_ready && !flush),
    .clr(cnt_clr),
    .cnt(stall_cnt)
  );

endmodule
